uart_tx: RTL and testbench

- Serial UART transmitter.
- Sits directly upstream of the UART receiver and drives its serial input line.
- Frames a size-bit parallel word as: start bit, data LSB-first, even parity, stop bit(s). Shifts out one bit per baud clock.
- Retransmits the held word when the receiver raises its resend flag (parity mismatch), up to a bounded retry count.

---
 rtl/uart_tx_pkg.sv | 23 ++
 rtl/uart_tx_shift.sv | 38 +++
 rtl/uart_tx.sv | 146 ++++++++++++++
 tb/tb_uart_tx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART framing definitions: state coding, line levels and frame length.
// The receiver reuses ST_IDLE with its own RECEIVE state on the same encoding.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic LVL_START  = 1'b0;
    localparam logic LVL_STOP   = 1'b1;
    localparam logic LVL_IDLE   = 1'b1;
    // Even parity: the parity bit is the plain XOR of the data bits.
    localparam logic PARITY_ODD = 1'b0;

    function automatic int frame_len(input int size, input int stop_bits);
        return 2 + size + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_shift.sv
// Hold and shift registers for the transmitter: parallel load, reload from hold, shift right.
// Parity is taken from the hold register so it stays valid while the shifter drains.
module uart_tx_shift
    import uart_tx_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic [SIZE-1:0] data_i,
    input  logic            reload_i,
    input  logic            shift_i,
    output logic            bit_o,
    output logic            parity_o
);

    logic [SIZE-1:0] hold_q;
    logic [SIZE-1:0] shift_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hold_q  <= '0;
            shift_q <= '0;
        end else if (load_i) begin
            hold_q  <= data_i;
            shift_q <= data_i;
        end else if (reload_i) begin
            shift_q <= hold_q;
        end else if (shift_i) begin
            shift_q <= shift_q >> 1;
        end
    end

    assign bit_o    = shift_q[0];
    assign parity_o = (^hold_q) ^ PARITY_ODD;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, even parity, stop bits; retransmits on receiver request.
// TxReady is low for the whole frame and while a resend is pending; all outputs are registered.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int size      = 32,
    parameter int STOP_BITS = 1,
    parameter int MAX_RETRY = 3
) (
    input  logic            CLK_Baudin,
    input  logic            RstTx,
    input  logic [size-1:0] DataIn,
    input  logic            TxValid,
    output logic            TxReady,
    input  logic            Flag_Rx,
    output logic            SerialOutputData,
    output logic            DoneTx,
    output logic            TxErr
);

    localparam int CW = $clog2(size) + 1;
    localparam int RW = $clog2(MAX_RETRY + 1) + 1;

    uart_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    stop_q;
    logic [RW-1:0] retry_q;
    logic          pending_q;
    logic          line_q;
    logic          ready_q;
    logic          done_q;
    logic          err_q;

    logic pending_now;
    logic accept;
    logic resend;
    logic give_up;
    logic shift_en;
    logic shift_bit;
    logic parity_bit;

    // A resend request seen in IDLE is acted on in the same cycle and beats a new word.
    always_comb begin
        pending_now = pending_q | Flag_Rx;
        accept      = (state_q == ST_IDLE) && ready_q && TxValid && !pending_now;
        resend      = (state_q == ST_IDLE) && pending_now && (retry_q < RW'(MAX_RETRY));
        give_up     = (state_q == ST_IDLE) && pending_now && !(retry_q < RW'(MAX_RETRY));
        shift_en    = (state_q == ST_START) ||
                      ((state_q == ST_DATA) && (cnt_q != CW'(size - 1)));
    end

    uart_tx_shift #(.SIZE(size)) u_shift (
        .clk_i    (CLK_Baudin),
        .rst_ni   (RstTx),
        .load_i   (accept),
        .data_i   (DataIn),
        .reload_i (resend),
        .shift_i  (shift_en),
        .bit_o    (shift_bit),
        .parity_o (parity_bit)
    );

    always_ff @(posedge CLK_Baudin) begin
        if (!RstTx) begin
            state_q   <= ST_IDLE;
            line_q    <= LVL_IDLE;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            stop_q    <= '0;
            retry_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if ((state_q != ST_IDLE) && Flag_Rx) begin
                pending_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    line_q <= LVL_IDLE;
                    if (resend) begin
                        retry_q   <= retry_q + 1'b1;
                        pending_q <= 1'b0;
                        ready_q   <= 1'b0;
                        line_q    <= LVL_START;
                        state_q   <= ST_START;
                    end else if (give_up) begin
                        err_q     <= 1'b1;
                        pending_q <= 1'b0;
                        retry_q   <= '0;
                        ready_q   <= 1'b1;
                    end else if (accept) begin
                        retry_q <= '0;
                        ready_q <= 1'b0;
                        line_q  <= LVL_START;
                        state_q <= ST_START;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_START: begin
                    line_q  <= shift_bit;
                    cnt_q   <= '0;
                    state_q <= ST_DATA;
                end
                ST_DATA: begin
                    if (cnt_q == CW'(size - 1)) begin
                        line_q  <= parity_bit;
                        state_q <= ST_PARITY;
                    end else begin
                        line_q <= shift_bit;
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    line_q  <= LVL_STOP;
                    stop_q  <= '0;
                    state_q <= ST_STOP;
                end
                ST_STOP: begin
                    line_q <= LVL_STOP;
                    if (stop_q == 2'(STOP_BITS - 1)) begin
                        done_q  <= !pending_now;
                        ready_q <= !pending_now;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        stop_q <= stop_q + 1'b1;
                    end
                end
                default: begin
                    line_q  <= LVL_IDLE;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign SerialOutputData = line_q;
    assign TxReady          = ready_q;
    assign DoneTx           = done_q;
    assign TxErr            = err_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: single frames from a vector table plus back-to-back, resend,
// retry exhaustion and mid-frame reset sequences. Inputs change and outputs are sampled on negedge.
module tb_uart_tx;
    import uart_tx_pkg::*;

    localparam int SIZE  = 32;
    localparam int STOPB = 1;
    localparam int FLEN  = frame_len(SIZE, STOPB);

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data;
    logic        valid;
    logic        flag;
    logic        ready;
    logic        line;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx #(.size(SIZE), .STOP_BITS(STOPB), .MAX_RETRY(3)) dut (
        .CLK_Baudin       (clk),
        .RstTx            (rst_n),
        .DataIn           (data),
        .TxValid          (valid),
        .TxReady          (ready),
        .Flag_Rx          (flag),
        .SerialOutputData (line),
        .DoneTx           (done),
        .TxErr            (err)
    );

    typedef struct {
        logic [31:0] word;
        logic        par;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Line bits in time order: start 0, data LSB first, parity, stop 1.
    function automatic logic [63:0] frame_bits(input logic [31:0] w, input logic par);
        logic [63:0] f;
        f       = '0;
        f[0]    = 1'b0;
        f[32:1] = w;
        f[33]   = par;
        f[34]   = 1'b1;
        return f;
    endfunction

    task automatic send(input logic [31:0] w);
        data  = w;
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    // Entered on the negedge of the start-bit cycle; leaves on the negedge of the last stop cycle.
    task automatic expect_frame(input string name, input logic [31:0] w, input logic par,
                                input int flag_at);
        logic [63:0] got;
        logic        side_bad;
        got      = '0;
        side_bad = 1'b0;
        for (int i = 0; i < FLEN; i++) begin
            got[i] = line;
            if (done || err || ready) side_bad = 1'b1;
            if (flag_at >= 0) flag = (i == flag_at);
            if (i < FLEN - 1) tick();
        end
        if (flag_at >= 0) flag = 1'b0;
        check({name, " bits"}, got, frame_bits(w, par));
        check({name, " quiet"}, {63'd0, side_bad}, 64'd0);
    endtask

    initial begin
        logic bad;

        vecs[0] = '{32'hA5A5_0001, 1'b1};
        vecs[1] = '{32'h1234_5678, 1'b1};
        vecs[2] = '{32'h0000_0000, 1'b0};
        vecs[3] = '{32'hFFFF_FFFF, 1'b0};
        vecs[4] = '{32'h8000_0000, 1'b1};

        rst_n = 1'b0;
        valid = 1'b0;
        flag  = 1'b0;
        data  = '0;
        tick();
        tick();
        check("rst line", line, 1);
        check("rst ready", ready, 0);
        check("rst done", done, 0);
        check("rst err", err, 0);
        rst_n = 1'b1;
        tick();
        check("post-rst ready", ready, 1);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!line || !ready || done || err) bad = 1'b1;
            tick();
        end
        check("idle 10", bad, 0);

        for (int v = 0; v < 5; v++) begin
            send(vecs[v].word);
            expect_frame($sformatf("vec%0d", v), vecs[v].word, vecs[v].par, -1);
            tick();
            check($sformatf("vec%0d done", v), {done, ready, line}, 3'b111);
            tick();
            check($sformatf("vec%0d done pulse", v), done, 0);
        end

        // Back-to-back with TxValid held: one idle-high cycle between frames.
        data  = 32'h0000_0000;
        valid = 1'b1;
        tick();
        data = 32'hFFFF_FFFF;
        expect_frame("b2b0", 32'h0000_0000, 1'b0, -1);
        tick();
        check("b2b gap", {done, ready, line}, 3'b111);
        tick();
        valid = 1'b0;
        expect_frame("b2b1", 32'hFFFF_FFFF, 1'b0, -1);
        tick();
        check("b2b done2", done, 1);
        tick();

        // Single resend requested mid-DATA.
        send(32'h1234_5678);
        expect_frame("rs0", 32'h1234_5678, 1'b1, 10);
        tick();
        check("rs gap", {done, ready, line}, 3'b001);
        tick();
        expect_frame("rs1", 32'h1234_5678, 1'b1, -1);
        tick();
        check("rs done", {done, ready}, 2'b11);
        tick();

        // Flag_Rx held: original plus three retries, then TxErr.
        send(32'hCAFE_F00D);
        flag = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expect_frame($sformatf("rt%0d", k), 32'hCAFE_F00D, 1'b0, -1);
            tick();
            check($sformatf("rt%0d gap", k), {done, err, ready, line}, 4'b0001);
            if (k < 3) tick();
        end
        tick();
        check("rt err", {err, ready, line, done}, 4'b1110);
        flag = 1'b0;
        tick();
        check("rt err pulse", {err, ready, line, done}, 4'b0110);
        send(32'h1234_5678);
        expect_frame("rt new0", 32'h1234_5678, 1'b1, 5);
        tick();
        check("rt new gap", {done, err, ready}, 3'b000);
        tick();
        expect_frame("rt new1", 32'h1234_5678, 1'b1, -1);
        tick();
        check("rt new done", done, 1);
        tick();

        // Reset asserted during data bit 10.
        send(32'hA5A5_0001);
        for (int i = 0; i < 11; i++) tick();
        rst_n = 1'b0;
        tick();
        check("mid rst", {line, ready, done, err}, 4'b1000);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!line || done || err) bad = 1'b1;
        end
        check("mid rst quiet", bad, 0);
        check("mid rst ready", ready, 1);
        send(32'h0000_FFFF);
        expect_frame("after rst", 32'h0000_FFFF, 1'b0, -1);
        tick();
        check("after rst done", done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
